// File: rtl/decode_issue.sv
// Decode/issue stage: decodes fetch instructions, reads the register file with writeback
// bypass, stalls on RAW hazards via a busy-bit scoreboard, and registers operands for the ALU.
module decode_issue #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned PC_WIDTH     = 32,
    parameter int unsigned NUM_REGS     = 32,
    parameter int unsigned OPCODE_WIDTH = 8
) (
    input  logic                        clock,
    input  logic                        reset_c,
    input  logic                        instr_valid,
    input  logic [31:0]                 instr_in,
    input  logic [PC_WIDTH-1:0]         pc_in,
    output logic                        stall_fetch,
    input  logic                        stall_alu,
    input  logic                        pcBranchVal,
    input  logic                        wb_en,
    input  logic [$clog2(NUM_REGS)-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0]       wb_data,
    output logic [DATA_WIDTH-1:0]       val1,
    output logic [DATA_WIDTH-1:0]       val2,
    output logic [OPCODE_WIDTH-1:0]     instr_out,
    output logic [$clog2(NUM_REGS)-1:0] rd_out,
    output logic [DATA_WIDTH-1:0]       store_data,
    output logic [PC_WIDTH-1:0]         pc_out
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);
    localparam int unsigned OFF_W = 14;

    localparam logic [OPCODE_WIDTH-1:0] OP_ADD   = OPCODE_WIDTH'(8'h00);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB   = OPCODE_WIDTH'(8'h01);
    localparam logic [OPCODE_WIDTH-1:0] OP_MUL   = OPCODE_WIDTH'(8'h02);
    localparam logic [OPCODE_WIDTH-1:0] OP_LDB   = OPCODE_WIDTH'(8'h10);
    localparam logic [OPCODE_WIDTH-1:0] OP_LDW   = OPCODE_WIDTH'(8'h11);
    localparam logic [OPCODE_WIDTH-1:0] OP_STB   = OPCODE_WIDTH'(8'h12);
    localparam logic [OPCODE_WIDTH-1:0] OP_STW   = OPCODE_WIDTH'(8'h13);
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = OPCODE_WIDTH'(8'h30);
    localparam logic [OPCODE_WIDTH-1:0] OP_JUMP  = OPCODE_WIDTH'(8'h31);
    localparam logic [OPCODE_WIDTH-1:0] OP_TLBWR = OPCODE_WIDTH'(8'h32);
    localparam logic [OPCODE_WIDTH-1:0] OP_IRET  = OPCODE_WIDTH'(8'h33);
    localparam logic [OPCODE_WIDTH-1:0] OP_NOP   = OPCODE_WIDTH'(8'hFF);

    typedef enum logic [1:0] {SEL_ZERO, SEL_REG, SEL_IMM} sel_e;

    logic [DATA_WIDTH-1:0]   rf [NUM_REGS];
    logic [NUM_REGS-1:0]     busy;
    logic [NUM_REGS-1:0]     busy_nxt;

    logic [OPCODE_WIDTH-1:0] raw_op;
    logic [OPCODE_WIDTH-1:0] dec_op;
    logic [IDX_W-1:0]        dec_rd;
    logic                    dec_writes;
    logic [IDX_W-1:0]        src_a, src_b, src_s;
    logic                    use_a, use_b, use_s;
    sel_e                    val2_sel, store_sel;
    logic [OFF_W-1:0]        off;
    logic [DATA_WIDTH-1:0]   imm;
    logic [DATA_WIDTH-1:0]   rdata_a, rdata_b, rdata_s;
    logic [DATA_WIDTH-1:0]   dec_val1, dec_val2, dec_store;
    logic                    haz_a, haz_b, haz_s, hazard, issue;

    assign raw_op = OPCODE_WIDTH'(instr_in[31:24]);
    assign off    = instr_in[13:0];
    assign imm    = {{(DATA_WIDTH-OFF_W){off[OFF_W-1]}}, off};

    // Field extraction and operand routing per opcode class
    always_comb begin
        dec_op     = OP_NOP;
        dec_rd     = '0;
        dec_writes = 1'b0;
        src_a      = '0;
        src_b      = '0;
        src_s      = '0;
        use_a      = 1'b0;
        use_b      = 1'b0;
        use_s      = 1'b0;
        val2_sel   = SEL_ZERO;
        store_sel  = SEL_ZERO;
        case (raw_op)
            OP_ADD, OP_SUB, OP_MUL: begin
                dec_op     = raw_op;
                dec_rd     = IDX_W'(instr_in[23:19]);
                dec_writes = 1'b1;
                src_a      = IDX_W'(instr_in[18:14]);
                src_b      = IDX_W'(instr_in[13:9]);
                use_a      = 1'b1;
                use_b      = 1'b1;
                val2_sel   = SEL_REG;
            end
            OP_LDB, OP_LDW: begin
                dec_op     = raw_op;
                dec_rd     = IDX_W'(instr_in[23:19]);
                dec_writes = 1'b1;
                src_a      = IDX_W'(instr_in[18:14]);
                use_a      = 1'b1;
                val2_sel   = SEL_IMM;
            end
            OP_STB, OP_STW: begin
                dec_op     = raw_op;
                src_s      = IDX_W'(instr_in[23:19]);
                src_a      = IDX_W'(instr_in[18:14]);
                use_a      = 1'b1;
                use_s      = 1'b1;
                val2_sel   = SEL_IMM;
                store_sel  = SEL_REG;
            end
            OP_BEQ: begin
                dec_op     = raw_op;
                src_a      = IDX_W'(instr_in[23:19]);
                src_b      = IDX_W'(instr_in[18:14]);
                use_a      = 1'b1;
                use_b      = 1'b1;
                val2_sel   = SEL_REG;
                store_sel  = SEL_IMM;
            end
            OP_JUMP: begin
                dec_op     = raw_op;
                src_a      = IDX_W'(instr_in[18:14]);
                use_a      = 1'b1;
            end
            OP_TLBWR, OP_IRET: begin
                dec_op     = raw_op;
                src_a      = IDX_W'(instr_in[18:14]);
                src_b      = IDX_W'(instr_in[13:9]);
                use_a      = 1'b1;
                use_b      = 1'b1;
                val2_sel   = SEL_REG;
            end
            default: ;
        endcase
    end

    // Register reads: R0 is hardwired zero, same-cycle writeback is forwarded
    assign rdata_a = (src_a == '0) ? '0 : (wb_en && wb_addr == src_a) ? wb_data : rf[src_a];
    assign rdata_b = (src_b == '0) ? '0 : (wb_en && wb_addr == src_b) ? wb_data : rf[src_b];
    assign rdata_s = (src_s == '0) ? '0 : (wb_en && wb_addr == src_s) ? wb_data : rf[src_s];

    assign dec_val1  = use_a ? rdata_a : '0;
    assign dec_val2  = (val2_sel == SEL_REG) ? rdata_b : (val2_sel == SEL_IMM) ? imm : '0;
    assign dec_store = (store_sel == SEL_REG) ? rdata_s : (store_sel == SEL_IMM) ? imm : '0;

    assign haz_a  = use_a && busy[src_a] && !(wb_en && wb_addr == src_a);
    assign haz_b  = use_b && busy[src_b] && !(wb_en && wb_addr == src_b);
    assign haz_s  = use_s && busy[src_s] && !(wb_en && wb_addr == src_s);
    assign hazard = haz_a || haz_b || haz_s;

    assign issue       = instr_valid && !hazard && !stall_alu && !pcBranchVal;
    assign stall_fetch = instr_valid && !issue;

    // Scoreboard: writeback and squash clear, issue sets (set wins on collision)
    always_comb begin
        busy_nxt = busy;
        if (wb_en) busy_nxt[wb_addr] = 1'b0;
        if (pcBranchVal && rd_out != '0) busy_nxt[rd_out] = 1'b0;
        if (issue && dec_writes && dec_rd != '0) busy_nxt[dec_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset_c) busy <= '0;
        else         busy <= busy_nxt;
    end

    always_ff @(posedge clock) begin
        if (reset_c) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) rf[i] <= '0;
        end else if (wb_en && wb_addr != '0) begin
            rf[wb_addr] <= wb_data;
        end
    end

    // Issue register towards the ALU
    always_ff @(posedge clock) begin
        if (reset_c) begin
            val1       <= '0;
            val2       <= '0;
            instr_out  <= OP_NOP;
            rd_out     <= '0;
            store_data <= '0;
            pc_out     <= '0;
        end else if (pcBranchVal) begin
            instr_out  <= OP_NOP;
            rd_out     <= '0;
        end else if (stall_alu) begin
            instr_out  <= instr_out;
        end else if (issue) begin
            val1       <= dec_val1;
            val2       <= dec_val2;
            instr_out  <= dec_op;
            rd_out     <= dec_writes ? dec_rd : '0;
            store_data <= dec_store;
            pc_out     <= pc_in;
        end else begin
            val1       <= '0;
            val2       <= '0;
            instr_out  <= OP_NOP;
            rd_out     <= '0;
            store_data <= '0;
            pc_out     <= '0;
        end
    end

endmodule

// File: tb/tb_decode_issue.sv
// Directed self-checking bench for decode_issue: operand mapping, RAW stalls, ALU stall,
// branch squash, R0 handling and mid-hazard reset.
module tb_decode_issue;

    logic        clock = 1'b0;
    logic        reset_c;
    logic        instr_valid;
    logic [31:0] instr_in;
    logic [31:0] pc_in;
    logic        stall_fetch;
    logic        stall_alu;
    logic        pcBranchVal;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] val1, val2, store_data, pc_out;
    logic [7:0]  instr_out;
    logic [4:0]  rd_out;

    int n_checks = 0;
    int n_fail   = 0;

    decode_issue dut (
        .clock       (clock),
        .reset_c     (reset_c),
        .instr_valid (instr_valid),
        .instr_in    (instr_in),
        .pc_in       (pc_in),
        .stall_fetch (stall_fetch),
        .stall_alu   (stall_alu),
        .pcBranchVal (pcBranchVal),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .val1        (val1),
        .val2        (val2),
        .instr_out   (instr_out),
        .rd_out      (rd_out),
        .store_data  (store_data),
        .pc_out      (pc_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] rtype(input logic [7:0] op, input logic [4:0] rd,
                                          input logic [4:0] ra, input logic [4:0] rb);
        return {op, rd, ra, rb, 9'b0};
    endfunction

    function automatic logic [31:0] itype(input logic [7:0] op, input logic [4:0] f1,
                                          input logic [4:0] f2, input logic [13:0] off);
        return {op, f1, f2, off};
    endfunction

    task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
        wb_en   = en;
        wb_addr = a;
        wb_data = d;
    endtask

    task automatic present(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        instr_valid = v;
        instr_in    = ins;
        pc_in       = pc;
    endtask

    initial begin
        reset_c = 1'b1;
        stall_alu = 1'b0;
        pcBranchVal = 1'b0;
        wb(1'b0, 5'd0, 32'd0);
        present(1'b0, 32'd0, 32'd0);
        tick();
        tick();
        reset_c = 1'b0;
        check("rst_instr", 64'(instr_out), 64'h00FF);
        check("rst_rd", 64'(rd_out), 64'd0);
        check("rst_val1", 64'(val1), 64'd0);
        check("rst_pc", 64'(pc_out), 64'd0);
        check("rst_stall", 64'(stall_fetch), 64'd0);

        // 1: writeback R1/R2 then ADD r3 = r1 + r2
        wb(1'b1, 5'd1, 32'd5);
        tick();
        wb(1'b1, 5'd2, 32'd7);
        tick();
        wb(1'b0, 5'd0, 32'd0);
        present(1'b1, rtype(8'h00, 5'd3, 5'd1, 5'd2), 32'd100);
        #1 check("add_nostall", 64'(stall_fetch), 64'd0);
        tick();
        check("add_val1", 64'(val1), 64'd5);
        check("add_val2", 64'(val2), 64'd7);
        check("add_op", 64'(instr_out), 64'h00);
        check("add_rd", 64'(rd_out), 64'd3);
        check("add_pc", 64'(pc_out), 64'd100);
        present(1'b1, rtype(8'h01, 5'd5, 5'd3, 5'd1), 32'd104);
        #1 check("busy3_stall", 64'(stall_fetch), 64'd1);
        wb(1'b1, 5'd3, 32'd12);
        #1 check("bypass3_nostall", 64'(stall_fetch), 64'd0);
        tick();
        check("sub_val1_byp", 64'(val1), 64'd12);
        check("sub_val2", 64'(val2), 64'd5);
        check("sub_rd", 64'(rd_out), 64'd5);
        present(1'b0, 32'd0, 32'd0);
        wb(1'b1, 5'd5, 32'd20);
        tick();
        check("bubble_op", 64'(instr_out), 64'hFF);
        wb(1'b0, 5'd0, 32'd0);

        // 2: LDW with negative offset, then dependent SUB stalls until writeback
        present(1'b1, itype(8'h11, 5'd4, 5'd1, 14'h3FFC), 32'd108);
        tick();
        check("ldw_val1", 64'(val1), 64'd5);
        check("ldw_val2", 64'(val2), 64'hFFFFFFFC);
        check("ldw_op", 64'(instr_out), 64'h11);
        check("ldw_rd", 64'(rd_out), 64'd4);
        present(1'b1, rtype(8'h01, 5'd7, 5'd4, 5'd2), 32'd112);
        for (int i = 0; i < 2; i++) begin
            #1 check("raw_stall", 64'(stall_fetch), 64'd1);
            tick();
            check("raw_bubble", 64'(instr_out), 64'hFF);
        end
        wb(1'b1, 5'd4, 32'd9);
        #1 check("raw_release", 64'(stall_fetch), 64'd0);
        tick();
        check("raw_val1", 64'(val1), 64'd9);
        check("raw_val2", 64'(val2), 64'd7);
        check("raw_op", 64'(instr_out), 64'h01);
        check("raw_pc", 64'(pc_out), 64'd112);
        present(1'b0, 32'd0, 32'd0);
        wb(1'b1, 5'd7, 32'd1);
        tick();
        wb(1'b0, 5'd0, 32'd0);

        // 3: stall_alu freezes the issue register
        present(1'b1, rtype(8'h00, 5'd8, 5'd1, 5'd2), 32'd200);
        tick();
        check("pre_stall_op", 64'(instr_out), 64'h00);
        stall_alu = 1'b1;
        present(1'b1, rtype(8'h02, 5'd9, 5'd2, 5'd2), 32'd204);
        for (int i = 0; i < 3; i++) begin
            #1 check("salu_stall", 64'(stall_fetch), 64'd1);
            tick();
            check("salu_hold_rd", 64'(rd_out), 64'd8);
            check("salu_hold_pc", 64'(pc_out), 64'd200);
            check("salu_hold_v1", 64'(val1), 64'd5);
        end
        stall_alu = 1'b0;
        #1 check("salu_release", 64'(stall_fetch), 64'd0);
        tick();
        check("mul_op", 64'(instr_out), 64'h02);
        check("mul_rd", 64'(rd_out), 64'd9);
        check("mul_val1", 64'(val1), 64'd7);
        check("mul_pc", 64'(pc_out), 64'd204);

        // 4: branch squashes ADD r6 and releases its busy bit
        present(1'b1, rtype(8'h00, 5'd6, 5'd1, 5'd1), 32'd300);
        tick();
        check("add6_rd", 64'(rd_out), 64'd6);
        pcBranchVal = 1'b1;
        present(1'b1, rtype(8'h00, 5'd10, 5'd6, 5'd0), 32'd304);
        #1 check("br_stall", 64'(stall_fetch), 64'd1);
        tick();
        pcBranchVal = 1'b0;
        check("br_squash_op", 64'(instr_out), 64'hFF);
        check("br_squash_rd", 64'(rd_out), 64'd0);
        #1 check("busy6_clear", 64'(stall_fetch), 64'd0);
        tick();
        check("post_br_op", 64'(instr_out), 64'h00);
        check("post_br_rd", 64'(rd_out), 64'd10);
        check("post_br_pc", 64'(pc_out), 64'd304);

        // 5: R0 is never busy and never written
        present(1'b1, rtype(8'h00, 5'd0, 5'd1, 5'd2), 32'd400);
        tick();
        check("rd0_rd", 64'(rd_out), 64'd0);
        present(1'b1, rtype(8'h00, 5'd11, 5'd0, 5'd1), 32'd404);
        #1 check("r0_nostall", 64'(stall_fetch), 64'd0);
        tick();
        check("r0_val1", 64'(val1), 64'd0);
        check("r0_val2", 64'(val2), 64'd5);
        present(1'b1, rtype(8'h00, 5'd12, 5'd0, 5'd0), 32'd408);
        wb(1'b1, 5'd0, 32'hDEAD);
        tick();
        check("r0_nobypass", 64'(val1), 64'd0);
        wb(1'b0, 5'd0, 32'd0);
        present(1'b1, rtype(8'h00, 5'd13, 5'd0, 5'd1), 32'd412);
        tick();
        check("r0_nowrite", 64'(val1), 64'd0);

        // Remaining operand mappings
        present(1'b1, itype(8'h13, 5'd1, 5'd2, 14'h0004), 32'd500);
        tick();
        check("stw_val1", 64'(val1), 64'd7);
        check("stw_val2", 64'(val2), 64'd4);
        check("stw_sdata", 64'(store_data), 64'd5);
        check("stw_rd", 64'(rd_out), 64'd0);
        present(1'b1, itype(8'h30, 5'd1, 5'd2, 14'h2000), 32'd504);
        tick();
        check("beq_val1", 64'(val1), 64'd5);
        check("beq_val2", 64'(val2), 64'd7);
        check("beq_sdata", 64'(store_data), 64'hFFFFE000);
        present(1'b1, rtype(8'h31, 5'd0, 5'd2, 5'd1), 32'd508);
        tick();
        check("jmp_val1", 64'(val1), 64'd7);
        check("jmp_val2", 64'(val2), 64'd0);
        present(1'b1, rtype(8'h05, 5'd3, 5'd1, 5'd2), 32'd512);
        tick();
        check("bad_op", 64'(instr_out), 64'hFF);
        check("bad_rd", 64'(rd_out), 64'd0);

        // 6: reset during a hazard stall clears scoreboard, RF and outputs
        present(1'b1, rtype(8'h00, 5'd14, 5'd8, 5'd1), 32'd600);
        #1 check("pre_rst_stall", 64'(stall_fetch), 64'd1);
        tick();
        reset_c = 1'b1;
        tick();
        reset_c = 1'b0;
        check("mrst_op", 64'(instr_out), 64'hFF);
        check("mrst_val1", 64'(val1), 64'd0);
        check("mrst_pc", 64'(pc_out), 64'd0);
        #1 check("mrst_nostall", 64'(stall_fetch), 64'd0);
        tick();
        check("mrst_issue_op", 64'(instr_out), 64'h00);
        check("mrst_rf_clr", 64'(val2), 64'd0);
        check("mrst_rd", 64'(rd_out), 64'd14);
        present(1'b0, 32'd0, 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_issue.md
Name: decode_issue

Overview:
- Decode/issue stage that feeds the ALU stage.
- Accepts raw 32-bit instructions from fetch and reads operands from an internal register file.
- Tracks pending destination writes with a busy-bit scoreboard and stalls on read-after-write hazards.
- Drives registered val1/val2/opcode/destination to the ALU, accepts the writeback port, and squashes the in-flight younger instruction when the ALU reports a taken branch.

Parameters:
- DATA_WIDTH, 32, width of registers and operands.
- PC_WIDTH, 32, program counter width.
- NUM_REGS, 32, architectural registers; index width is log2(NUM_REGS) = 5.
- OPCODE_WIDTH, 8, opcode field width.

Ports:
- clock  in  1  single clock, all state on the rising edge.
- reset_c  in  1  synchronous, active-high reset.
- instr_valid  in  1  fetch presents an instruction.
- instr_in  in  32  raw instruction.
- pc_in  in  PC_WIDTH  PC of instr_in.
- stall_fetch  out  1  combinational; fetch must hold instr_in/pc_in when high.
- stall_alu  in  1  ALU cannot accept; issue register holds.
- pcBranchVal  in  1  ALU reports taken branch/jump this cycle.
- wb_en  in  1  writeback strobe.
- wb_addr  in  5  writeback register index.
- wb_data  in  DATA_WIDTH  writeback data.
- val1  out  DATA_WIDTH  operand A to ALU.
- val2  out  DATA_WIDTH  operand B / sign-extended offset.
- instr_out  out  OPCODE_WIDTH  opcode to ALU; 8'hFF = NOP.
- rd_out  out  5  destination index.
- store_data  out  DATA_WIDTH  register value for stores.
- pc_out  out  PC_WIDTH  PC of issued instruction.

Behaviour:
- Instruction fields:
  - opcode = instr_in[31:24].
  - R-type: rd [23:19], ra [18:14], rb [13:9].
  - Memory (10–13): rd/rs [23:19], ra [18:14], off [13:0].
  - BEQ (30): ra [23:19], rb [18:14], off [13:0].
  - JUMP (31): ra [18:14].
- Operand mapping:
  - ADD/SUB/MUL (00/01/02): val1 = R[ra], val2 = R[rb]; writes rd.
  - LDB/LDW (10/11): val1 = R[ra], val2 = sext(off); writes rd.
  - STB/STW (12/13): val1 = R[ra], val2 = sext(off), store_data = R[rs]; no write.
  - BEQ: val1 = R[ra], val2 = R[rb], store_data = sext(off); no write.
  - JUMP: val1 = R[ra], val2 = 0; no write.
  - TLBWRITE (32) and IRET (33): pass through with val1 = R[ra], val2 = R[rb]; no write.
  - Any other opcode issues as NOP (8'hFF) with rd_out = 0.
- Register file:
  - NUM_REGS x DATA_WIDTH.
  - R0 always reads 0; writes to index 0 are ignored.
  - Write on rising edge when wb_en = 1.
- Read bypass: if wb_en = 1 and wb_addr == the source index (nonzero), the read returns wb_data in the same cycle.
- Scoreboard (busy[NUM_REGS]):
  - On issue of a writing instruction with rd != 0, set busy[rd].
  - On wb_en, clear busy[wb_addr].
  - If set and clear hit the same index in the same cycle, set wins.
- Hazard: the instruction stalls when any source it uses has busy = 1 and is not satisfied by the same-cycle writeback bypass.
- Issue condition: issue = instr_valid & ~hazard & ~stall_alu & ~pcBranchVal.
- stall_fetch = instr_valid & ~issue.
- Latency: 1 cycle. Operands appear on the outputs the cycle after the issue edge.
- Issue register update, in priority order:
  1. reset_c: all outputs cleared (instr_out = 8'hFF, others 0), register file cleared to 0, busy cleared.
  2. pcBranchVal: instr_out <= 8'hFF and rd_out <= 0. The busy bit set by the squashed issue-register instruction (if it writes) is cleared. The presented instruction is not accepted; fetch redirects.
  3. stall_alu: hold all outputs; no scoreboard set.
  4. issue: load the new values.
  5. Otherwise: load a NOP bubble.
- Writeback continues during stall_alu and hazards.
- Reset mid-operation discards any in-flight instruction with no residual busy bits.

Test Plan:
1. Reset, then wb R1 = 5 and R2 = 7; then issue ADD rd=3, ra=1, rb=2 -> next cycle val1 = 5, val2 = 7, instr_out = 00, rd_out = 3; busy[3] = 1.
2. LDW rd=4, ra=1, off=14'h3FFC, immediately followed by SUB ra=4 -> LDW issues with val2 = 32'hFFFFFFFC. SUB holds with stall_fetch = 1 and instr_out = FF bubbles until wb_en for R4 = 9; SUB then issues in that same cycle with val1 = 9 (bypass).
3. stall_alu = 1 for 3 cycles with a valid instruction waiting -> outputs frozen, stall_fetch = 1; the instruction issues on the first cycle after stall_alu falls.
4. pcBranchVal = 1 while the issue register holds ADD rd=6 -> next cycle instr_out = FF, busy[6] = 0, the presented instruction is not accepted.
5. ADD rd=0, then an instruction reading R0 -> no stall, val1 = 0; wb to R0 with data 32'hDEAD leaves R0 reading 0.
6. Assert reset_c during a hazard stall -> next cycle all outputs are NOP/0, busy all 0, stall_fetch = 0 for any instruction with no hazard.
